spi_ram_arbiter: RTL and testbench

- Shares the single command-driven RAM port between two requesters, A and B (e.g. the SPI slave and a local host).
- Each requester issues 10-bit command words {op[1:0], payload[7:0]}:
  - op 00: write address
  - op 01: write data
  - op 10: read address
  - op 11: read data
- The RAM holds its write and read addresses internally, so the arbiter locks ownership across a full address+data transaction.
- It returns read data only to the owner, and forces a timeout release if an owner stalls.

---
 rtl/spi_ram_arb_pkg.sv | 35 +++
 rtl/arb_rr_pick2.sv | 35 +++
 rtl/spi_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_arb_pkg.sv
// Shared opcodes, state/owner encodings and the opcode-driven state step
// for the two-requester RAM command arbiter.
package spi_ram_arb_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOCK_WR = 2'b01,
        LOCK_RD = 2'b10,
        WAIT_RD = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_e;

    // Write data only closes the transaction when no read address is pending.
    function automatic arb_state_e state_after_op(input logic [1:0] op, input arb_state_e cur);
        arb_state_e nxt;
        unique case (op)
            OP_WR_ADDR: nxt = LOCK_WR;
            OP_RD_ADDR: nxt = LOCK_RD;
            OP_RD_DATA: nxt = WAIT_RD;
            default:    nxt = (cur == LOCK_RD) ? LOCK_RD : IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/arb_rr_pick2.sv
// Two-request round-robin picker; the priority flips away from whoever
// releases the RAM.
module arb_rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic release_i,
    input  logic release_a_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    logic prio_b_q;
    logic prio_b_d;

    always_comb begin
        prio_b_d = prio_b_q;
        if (release_i) begin
            prio_b_d = release_a_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

    assign grant_a_o = req_a_i && (!req_b_i || !prio_b_q);
    assign grant_b_o = req_b_i && (!req_a_i || prio_b_q);

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one command-driven RAM port between requesters A and B, locking
// ownership across address+data transactions with a stall timeout.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16,
    parameter int TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE+1:0] a_cmd,
    input  logic                 a_valid,
    output logic                 a_ready,
    output logic [ADDR_SIZE-1:0] a_rdata,
    output logic                 a_rvalid,
    input  logic [ADDR_SIZE+1:0] b_cmd,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [ADDR_SIZE-1:0] b_rdata,
    output logic                 b_rvalid,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic [1:0]           owner,
    output logic                 timeout
);

    arb_state_e           state_q;
    owner_e               owner_q;
    logic [TO_W-1:0]      cnt_q;
    logic [ADDR_SIZE+1:0] ram_din_q;
    logic                 ram_rx_valid_q;
    logic [ADDR_SIZE-1:0] a_rdata_q;
    logic [ADDR_SIZE-1:0] b_rdata_q;
    logic                 a_rvalid_q;
    logic                 b_rvalid_q;
    logic                 timeout_q;

    logic                 grant_a;
    logic                 grant_b;
    logic                 xfer;
    logic [ADDR_SIZE+1:0] xfer_cmd;
    logic [1:0]           xfer_op;
    arb_state_e           op_state;
    logic                 rel_op;
    logic                 rel_data;
    logic                 expire;
    logic                 release_any;
    logic                 release_a;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                a_ready = grant_a;
                b_ready = grant_b;
            end
            LOCK_WR, LOCK_RD: begin
                a_ready = a_valid && (owner_q == OWN_A);
                b_ready = b_valid && (owner_q == OWN_B);
            end
            default: begin
                a_ready = 1'b0;
                b_ready = 1'b0;
            end
        endcase
    end

    assign xfer     = a_ready || b_ready;
    assign xfer_cmd = a_ready ? a_cmd : b_cmd;
    assign xfer_op  = xfer_cmd[ADDR_SIZE+1 -: 2];
    assign op_state = state_after_op(xfer_op, state_q);

    // An owner transfer or returning read data always beats the stall limit.
    assign rel_op   = xfer && (op_state == IDLE);
    assign rel_data = (state_q == WAIT_RD) && ram_tx_valid;
    assign expire   = (state_q != IDLE) && !xfer && !rel_data
                      && (cnt_q == TO_W'(TIMEOUT - 1));

    assign release_any = rel_op || rel_data || expire;
    assign release_a   = rel_op ? a_ready : (owner_q == OWN_A);

    arb_rr_pick2 u_pick (
        .clk        (clk),
        .rst        (rst),
        .req_a_i    (a_valid),
        .req_b_i    (b_valid),
        .release_i  (release_any),
        .release_a_i(release_a),
        .grant_a_o  (grant_a),
        .grant_b_o  (grant_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_NONE;
            cnt_q          <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            ram_rx_valid_q <= xfer;
            if (xfer) begin
                ram_din_q <= xfer_cmd;
            end
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            timeout_q  <= 1'b0;

            if (xfer) begin
                state_q <= op_state;
                cnt_q   <= '0;
                if (op_state == IDLE) begin
                    owner_q <= OWN_NONE;
                end else if (state_q == IDLE) begin
                    owner_q <= b_ready ? OWN_B : OWN_A;
                end
            end else if (rel_data) begin
                if (owner_q == OWN_B) begin
                    b_rdata_q  <= ram_dout;
                    b_rvalid_q <= 1'b1;
                end else begin
                    a_rdata_q  <= ram_dout;
                    a_rvalid_q <= 1'b1;
                end
                state_q <= IDLE;
                owner_q <= OWN_NONE;
                cnt_q   <= '0;
            end else if (expire) begin
                timeout_q <= 1'b1;
                state_q   <= IDLE;
                owner_q   <= OWN_NONE;
                cnt_q     <= '0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + TO_W'(1);
            end
        end
    end

    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign a_rvalid     = a_rvalid_q;
    assign b_rvalid     = b_rvalid_q;
    assign owner        = owner_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level ownership model.
module tb_spi_ram_arbiter;

    localparam int AW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW+1:0] a_cmd = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [AW-1:0] a_rdata;
    logic          a_rvalid;
    logic [AW+1:0] b_cmd = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_rdata;
    logic          b_rvalid;
    logic [AW+1:0] ram_din;
    logic          ram_rx_valid;
    logic [AW-1:0] ram_dout = '0;
    logic          ram_tx_valid = 1'b0;
    logic [1:0]    owner;
    logic          timeout;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.ADDR_SIZE(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_cmd       (a_cmd),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_rdata     (a_rdata),
        .a_rvalid    (a_rvalid),
        .b_cmd       (b_cmd),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_rdata     (b_rdata),
        .b_rvalid    (b_rvalid),
        .ram_din     (ram_din),
        .ram_rx_valid(ram_rx_valid),
        .ram_dout    (ram_dout),
        .ram_tx_valid(ram_tx_valid),
        .owner       (owner),
        .timeout     (timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: who holds the RAM, whether a read address is pending, whether
    // read data is awaited, whose turn it is on contention, stall cycles.
    int            m_owner;
    bit            m_rd;
    bit            m_wait;
    bit            m_prio_b;
    int            m_idle;
    logic [AW+1:0] e_din;
    bit            e_rxv;
    logic [AW-1:0] e_ardata;
    logic [AW-1:0] e_brdata;
    bit            e_arv;
    bit            e_brv;
    bit            e_to;
    bit            exp_a_rdy;
    bit            exp_b_rdy;
    bit            obs_a_rdy;
    bit            obs_b_rdy;

    task automatic model_reset();
        m_owner  = 0;
        m_rd     = 0;
        m_wait   = 0;
        m_prio_b = 0;
        m_idle   = 0;
        e_din    = '0;
        e_rxv    = 0;
        e_ardata = '0;
        e_brdata = '0;
        e_arv    = 0;
        e_brv    = 0;
        e_to     = 0;
    endtask

    task automatic model_release(input string why);
        $display("txn %s released by requester %s at %0t", why, (m_owner == 1) ? "A" : "B", $time);
        m_prio_b = (m_owner == 1);
        m_owner  = 0;
        m_rd     = 0;
        m_wait   = 0;
        m_idle   = 0;
    endtask

    // One clock: drive inputs after the falling edge, check readies, advance
    // the model, then check the registered outputs after the rising edge.
    task automatic cycle(input bit av, input logic [AW+1:0] ac, input bit bv, input logic [AW+1:0] bc,
                         input bit tv, input logic [AW-1:0] td);
        logic [AW+1:0] cmd;
        int who;
        a_valid = av;
        a_cmd = ac;
        b_valid = bv;
        b_cmd = bc;
        ram_tx_valid = tv;
        ram_dout = td;
        #1;
        exp_a_rdy = 0;
        exp_b_rdy = 0;
        if (m_owner == 0) begin
            if (av && bv) begin
                exp_a_rdy = !m_prio_b;
                exp_b_rdy = m_prio_b;
            end else begin
                exp_a_rdy = av;
                exp_b_rdy = bv;
            end
        end else if (!m_wait) begin
            exp_a_rdy = av && (m_owner == 1);
            exp_b_rdy = bv && (m_owner == 2);
        end
        obs_a_rdy = a_ready;
        obs_b_rdy = b_ready;
        check_eq("a_ready", a_ready, exp_a_rdy);
        check_eq("b_ready", b_ready, exp_b_rdy);

        e_rxv = 0;
        e_arv = 0;
        e_brv = 0;
        e_to  = 0;
        if (exp_a_rdy || exp_b_rdy) begin
            who = exp_a_rdy ? 1 : 2;
            cmd = exp_a_rdy ? ac : bc;
            e_din = cmd;
            e_rxv = 1;
            m_idle = 0;
            if (m_owner == 0) m_owner = who;
            case (cmd[AW+1:AW])
                2'b00:   m_rd = 0;
                2'b10:   m_rd = 1;
                2'b11:   m_wait = 1;
                default: if (!m_rd) model_release("write");
            endcase
        end else if (m_owner != 0) begin
            if (m_wait && tv) begin
                if (m_owner == 1) begin
                    e_ardata = td;
                    e_arv = 1;
                end else begin
                    e_brdata = td;
                    e_brv = 1;
                end
                model_release("read");
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    e_to = 1;
                    model_release("timeout");
                end
            end
        end

        @(posedge clk);
        #1;
        check_eq("ram_rx_valid", ram_rx_valid, e_rxv);
        check_eq("ram_din", ram_din, e_din);
        check_eq("a_rvalid", a_rvalid, e_arv);
        check_eq("a_rdata", a_rdata, e_ardata);
        check_eq("b_rvalid", b_rvalid, e_brv);
        check_eq("b_rdata", b_rdata, e_brdata);
        check_eq("timeout", timeout, e_to);
        check_eq("owner", owner, m_owner);
        @(negedge clk);
    endtask

    // Asynchronous reset raised between clock edges; outputs must clear at once.
    task automatic apply_reset();
        a_valid = 0;
        b_valid = 0;
        ram_tx_valid = 0;
        rst = 1;
        #1;
        check_eq("rst_ram_din", ram_din, 0);
        check_eq("rst_rx_valid", ram_rx_valid, 0);
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
        check_eq("rst_a_rvalid", a_rvalid, 0);
        check_eq("rst_b_rvalid", b_rvalid, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_readies", {a_ready, b_ready}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    bit            ra_v;
    bit            rb_v;
    logic [AW+1:0] ra_c;
    logic [AW+1:0] rb_c;
    int            dens;

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // Write transaction by A.
        cycle(1, 10'h005, 0, 0, 0, 0);
        check_eq("wr_din_addr", ram_din, 10'h005);
        check_eq("wr_owner_a", owner, 2'b01);
        cycle(1, 10'h1A5, 0, 0, 0, 0);
        check_eq("wr_din_data", ram_din, 10'h1A5);
        check_eq("wr_owner_none", owner, 2'b00);

        // Read transaction by B.
        cycle(0, 0, 1, 10'h205, 0, 0);
        cycle(0, 0, 1, 10'h300, 0, 0);
        cycle(0, 0, 0, 0, 1, 8'hA5);
        check_eq("rd_b_rdata", b_rdata, 8'hA5);
        check_eq("rd_b_rvalid", b_rvalid, 1);
        check_eq("rd_a_rvalid", a_rvalid, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Contention from reset: A, B, A, B.
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            cycle(1, 10'h011, 1, 10'h022, 0, 0);
            check_eq("cont_owner", owner, (r % 2 == 0) ? 2'b01 : 2'b10);
            if (r % 2 == 0) cycle(1, 10'h155, 1, 10'h022, 0, 0);
            else            cycle(1, 10'h011, 1, 10'h1AA, 0, 0);
            check_eq("cont_release", owner, 2'b00);
        end

        // Timeout with B pending.
        cycle(1, 10'h010, 0, 0, 0, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            cycle(0, 0, 1, 10'h0B0, 0, 0);
            if (k < TIMEOUT) check_eq("to_early", timeout, 0);
        end
        check_eq("to_pulse", timeout, 1);
        check_eq("to_owner", owner, 2'b00);
        cycle(0, 0, 1, 10'h0B0, 0, 0);
        check_eq("to_b_grant", obs_b_rdy, 1);
        cycle(0, 0, 1, 10'h1B1, 0, 0);

        // Spurious RAM data and an orphan write-data word.
        cycle(0, 0, 0, 0, 1, 8'h5A);
        check_eq("spur_a_rvalid", a_rvalid, 0);
        check_eq("spur_b_rvalid", b_rvalid, 0);
        cycle(1, 10'h1FF, 0, 0, 0, 0);
        check_eq("orph_din", ram_din, 10'h1FF);
        check_eq("orph_owner", owner, 2'b00);
        cycle(0, 0, 1, 10'h033, 0, 0);
        check_eq("orph_b_grant", obs_b_rdy, 1);
        cycle(0, 0, 1, 10'h144, 0, 0);

        // Read data arriving on the same cycle the stall limit expires.
        cycle(1, 10'h200, 0, 0, 0, 0);
        cycle(1, 10'h300, 0, 0, 0, 0);
        for (int k = 1; k < TIMEOUT; k++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 8'h3C);
        check_eq("tie_rvalid", a_rvalid, 1);
        check_eq("tie_timeout", timeout, 0);

        // Reset while waiting for read data.
        cycle(0, 0, 1, 10'h2C0, 0, 0);
        cycle(0, 0, 1, 10'h300, 0, 0);
        apply_reset();
        cycle(0, 0, 0, 0, 1, 8'h77);
        check_eq("rst_wait_b_rvalid", b_rvalid, 0);

        // Randomized traffic; an unaccepted word is usually held.
        ra_v = 0;
        rb_v = 0;
        ra_c = '0;
        rb_c = '0;
        dens = 30;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(3))
                    0:       dens = 3;
                    1:       dens = 30;
                    2:       dens = 70;
                    default: dens = 95;
                endcase
            end
            if ($urandom_range(999) == 0) apply_reset();
            cycle(ra_v, ra_c, rb_v, rb_c, $urandom_range(99) < 25, 8'($urandom));
            if (!(ra_v && !obs_a_rdy && $urandom_range(99) < 80)) begin
                ra_v = $urandom_range(99) < dens;
                ra_c = 10'($urandom);
            end
            if (!(rb_v && !obs_b_rdy && $urandom_range(99) < 80)) begin
                rb_v = $urandom_range(99) < dens;
                rb_c = 10'($urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
